wired_arf_read_sched: RTL and testbench

//  Read-port scheduler for the banked architectural register file (ARF) in the backend rename stage.

---
 rtl/wired_arf_read_sched_if.sv | 39 +++
 rtl/wired_arf_read_sched.sv | 132 +++++++++++++
 tb/tb_wired_arf_read_sched.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/wired_arf_read_sched_if.sv
// Bundle of requester-side and ARF-side signals for the ARF read-port scheduler.
//   slave  : used by the scheduler (takes requests, ARF read data and commit writes;
//            returns grants, responses and ARF read addresses)
//   master : used by the environment (requesters + ARF)
// Signals:
//   flush                backend flush, kills in-flight responses
//   req_valid/req_addr   per-requester operand read request (arch register index)
//   req_ready            per-requester grant, combinational
//   resp_valid/resp_data per-requester read response, one cycle after grant
//   raddr/rdata          ARF read ports (registered read in the ARF)
//   we/waddr/wdata       commit write ports observed for forwarding
interface wired_arf_read_sched_if #(
  parameter int REQ_CNT      = 6,
  parameter int R_PORT_COUNT = 4,
  parameter int W_PORT_COUNT = 2,
  parameter int DATA_WIDTH   = 32
);
  logic                                      flush;
  logic [REQ_CNT-1:0]                        req_valid;
  logic [REQ_CNT-1:0][4:0]                   req_addr;
  logic [REQ_CNT-1:0]                        req_ready;
  logic [REQ_CNT-1:0]                        resp_valid;
  logic [REQ_CNT-1:0][DATA_WIDTH-1:0]        resp_data;
  logic [R_PORT_COUNT-1:0][4:0]              raddr;
  logic [R_PORT_COUNT-1:0][DATA_WIDTH-1:0]   rdata;
  logic [W_PORT_COUNT-1:0]                   we;
  logic [W_PORT_COUNT-1:0][4:0]              waddr;
  logic [W_PORT_COUNT-1:0][DATA_WIDTH-1:0]   wdata;

  modport master (
    output flush, req_valid, req_addr, rdata, we, waddr, wdata,
    input  req_ready, resp_valid, resp_data, raddr
  );

  modport slave (
    input  flush, req_valid, req_addr, rdata, we, waddr, wdata,
    output req_ready, resp_valid, resp_data, raddr
  );
endinterface

// File: rtl/wired_arf_read_sched.sv
// Read-port scheduler for the banked architectural register file.
// Shares R_PORT_COUNT ARF read ports among REQ_CNT operand requesters using a
// round-robin scan, with a fixed one-cycle read latency. Commit writes that hit
// a register being read in the grant cycle are forwarded so the response holds
// the latest architectural value.
// Ports:
//   clk    clock
//   rst_n  asynchronous reset, active low
//   bus    wired_arf_read_sched_if.slave (requests, responses, ARF ports, flush)
module wired_arf_read_sched #(
  parameter int REQ_CNT      = 6,
  parameter int R_PORT_COUNT = 4,
  parameter int W_PORT_COUNT = 2,
  parameter int DATA_WIDTH   = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  wired_arf_read_sched_if.slave  bus
);

  localparam int PTR_W  = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
  localparam int PORT_W = (R_PORT_COUNT > 1) ? $clog2(R_PORT_COUNT) : 1;

  logic [PTR_W-1:0]                        rr_ptr;
  logic [PTR_W-1:0]                        rr_ptr_next;
  logic [PTR_W-1:0]                        idx;
  logic [PTR_W-1:0]                        last_idx;
  logic [PORT_W:0]                         used;
  logic                                    denied;
  int                                      sum;
  logic [REQ_CNT-1:0]                      grant;
  logic [REQ_CNT-1:0][PORT_W-1:0]          port_sel;
  logic [R_PORT_COUNT-1:0][4:0]            raddr_int;
  logic [REQ_CNT-1:0]                      zero_req;
  logic [REQ_CNT-1:0]                      fwd_hit;
  logic [REQ_CNT-1:0][DATA_WIDTH-1:0]      fwd_data;

  logic [REQ_CNT-1:0]                      grant_q;
  logic [REQ_CNT-1:0][PORT_W-1:0]          port_q;
  logic [REQ_CNT-1:0]                      zero_q;
  logic [REQ_CNT-1:0]                      fwd_hit_q;
  logic [REQ_CNT-1:0][DATA_WIDTH-1:0]      fwd_data_q;

  // Round-robin scan starting at rr_ptr. x0 reads are granted for free; the
  // first R_PORT_COUNT non-zero requests get ports in scan order. The pointer
  // only moves when someone was denied, to just past the last port winner.
  always_comb begin
    grant       = '0;
    port_sel    = '0;
    raddr_int   = '0;
    used        = '0;
    denied      = 1'b0;
    last_idx    = '0;
    idx         = '0;
    sum         = 0;
    rr_ptr_next = rr_ptr;
    for (int i = 0; i < REQ_CNT; i++) begin
      sum = int'(rr_ptr) + i;
      idx = PTR_W'((sum >= REQ_CNT) ? sum - REQ_CNT : sum);
      if (bus.req_valid[idx]) begin
        if (bus.req_addr[idx] == 5'd0) begin
          grant[idx] = 1'b1;
        end else if (used < (PORT_W+1)'(R_PORT_COUNT)) begin
          grant[idx]                    = 1'b1;
          port_sel[idx]                 = used[PORT_W-1:0];
          raddr_int[used[PORT_W-1:0]]   = bus.req_addr[idx];
          used                          = used + 1'b1;
          last_idx                      = idx;
        end else begin
          denied = 1'b1;
        end
      end
    end
    if (denied) begin
      rr_ptr_next = (last_idx == PTR_W'(REQ_CNT-1)) ? '0 : last_idx + 1'b1;
    end
  end

  // The ARF returns the pre-write value on a same-cycle read/write, so capture
  // the colliding commit data now. Later write ports overwrite earlier ones.
  always_comb begin
    zero_req = '0;
    fwd_hit  = '0;
    fwd_data = '0;
    for (int k = 0; k < REQ_CNT; k++) begin
      zero_req[k] = (bus.req_addr[k] == 5'd0);
      for (int w = 0; w < W_PORT_COUNT; w++) begin
        if (bus.we[w] && (bus.waddr[w] == bus.req_addr[k]) && !zero_req[k]) begin
          fwd_hit[k]  = 1'b1;
          fwd_data[k] = bus.wdata[w];
        end
      end
    end
  end

  assign bus.req_ready = rst_n ? grant : '0;
  assign bus.raddr     = rst_n ? raddr_int : '0;

  // Grant-cycle state carried into the response cycle. A flush during the
  // grant cycle drops the grant here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      grant_q    <= '0;
      port_q     <= '0;
      zero_q     <= '0;
      fwd_hit_q  <= '0;
      fwd_data_q <= '0;
    end else begin
      rr_ptr     <= rr_ptr_next;
      grant_q    <= grant & {REQ_CNT{~bus.flush}};
      port_q     <= port_sel;
      zero_q     <= zero_req;
      fwd_hit_q  <= fwd_hit;
      fwd_data_q <= fwd_data;
    end
  end

  // Response: flush in the response cycle also kills the pulse. Data is x0,
  // then forwarded commit data, then the ARF port the request was given.
  always_comb begin
    bus.resp_valid = '0;
    bus.resp_data  = '0;
    for (int k = 0; k < REQ_CNT; k++) begin
      bus.resp_valid[k] = grant_q[k] & ~bus.flush;
      if (grant_q[k] && !zero_q[k]) begin
        bus.resp_data[k] = fwd_hit_q[k] ? fwd_data_q[k] : bus.rdata[port_q[k]];
      end
    end
  end

endmodule

// File: tb/tb_wired_arf_read_sched.sv
// Directed bench for wired_arf_read_sched: reset, contention, x0, forwarding,
// flush and mid-flight async reset, with hand-computed expectations.
module tb_wired_arf_read_sched;

  localparam int REQ_CNT      = 6;
  localparam int R_PORT_COUNT = 4;
  localparam int W_PORT_COUNT = 2;
  localparam int DATA_WIDTH   = 32;

  logic        clk;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] arf [32];

  wired_arf_read_sched_if #(
    .REQ_CNT(REQ_CNT), .R_PORT_COUNT(R_PORT_COUNT),
    .W_PORT_COUNT(W_PORT_COUNT), .DATA_WIDTH(DATA_WIDTH)
  ) bus ();

  wired_arf_read_sched #(
    .REQ_CNT(REQ_CNT), .R_PORT_COUNT(R_PORT_COUNT),
    .W_PORT_COUNT(W_PORT_COUNT), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Initial ARF contents: r5 = 0x1111, every other rN = N * 0x1111, r0 = 0.
  function automatic logic [31:0] arf_init(input int r);
    if (r == 5) return 32'h1111;
    return 32'(r * 32'h1111);
  endfunction

  // ARF model: registered read returning the pre-write value, commit writes
  // with the higher write port winning; contents reload while in reset.
  always @(posedge clk) begin
    for (int p = 0; p < R_PORT_COUNT; p++) bus.rdata[p] <= arf[bus.raddr[p]];
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) arf[r] <= arf_init(r);
    end else begin
      for (int w = 0; w < W_PORT_COUNT; w++)
        if (bus.we[w] && bus.waddr[w] != 5'd0) arf[bus.waddr[w]] <= bus.wdata[w];
    end
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [5:0] valid, input logic [5:0][4:0] addr,
                                input logic flush);
    bus.req_valid = valid;
    bus.req_addr  = addr;
    bus.flush     = flush;
  endtask

  task automatic set_writes(input logic [1:0] we, input logic [1:0][4:0] waddr,
                            input logic [1:0][31:0] wdata);
    bus.we    = we;
    bus.waddr = waddr;
    bus.wdata = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset with random traffic on every input
    rst_n         = 1'b0;
    bus.req_valid = 6'($urandom);
    bus.req_addr  = 30'($urandom);
    bus.flush     = 1'b0;
    bus.we        = 2'($urandom);
    bus.waddr     = 10'($urandom);
    bus.wdata     = 64'({$urandom, $urandom});
    #1;
    check_output("reset_ready", 64'(bus.req_ready), 64'h0);
    check_output("reset_raddr", 64'(bus.raddr), 64'h0);
    check_output("reset_resp_valid", 64'(bus.resp_valid), 64'h0);
    check_output("reset_resp_data", 64'(|bus.resp_data), 64'h0);
    next_cycle();
    next_cycle();
    check_output("reset_ready_hold", 64'(bus.req_ready), 64'h0);
    check_output("reset_resp_valid_hold", 64'(bus.resp_valid), 64'h0);

    // Contention C0: all six valid r1..r6 from rr_ptr=0
    rst_n = 1'b1;
    set_writes(2'b00, '0, '0);
    apply_stimulus(6'b111111, {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 1'b0);
    #1;
    check_output("c0_ready", 64'(bus.req_ready), 64'(6'b001111));
    check_output("c0_raddr", 64'(bus.raddr), 64'({5'd4, 5'd3, 5'd2, 5'd1}));
    next_cycle();
    check_output("c0_resp_valid", 64'(bus.resp_valid), 64'(6'b001111));
    check_output("c0_data0", 64'(bus.resp_data[0]), 64'h1111);
    check_output("c0_data1", 64'(bus.resp_data[1]), 64'h2222);
    check_output("c0_data2", 64'(bus.resp_data[2]), 64'h3333);
    check_output("c0_data3", 64'(bus.resp_data[3]), 64'h4444);

    // Contention C1: rr_ptr=4 -> grants 4,5,0,1; rr_ptr then 2
    #1;
    check_output("c1_ready", 64'(bus.req_ready), 64'(6'b110011));
    check_output("c1_raddr", 64'(bus.raddr), 64'({5'd2, 5'd1, 5'd6, 5'd5}));
    next_cycle();
    check_output("c1_resp_valid", 64'(bus.resp_valid), 64'(6'b110011));
    check_output("c1_data4", 64'(bus.resp_data[4]), 64'h1111);
    check_output("c1_data5", 64'(bus.resp_data[5]), 64'h6666);
    check_output("c1_data0", 64'(bus.resp_data[0]), 64'h1111);
    check_output("c1_data1", 64'(bus.resp_data[1]), 64'h2222);

    // x0: req0 reads r0 for free; five r7 reads share four ports from rr_ptr=2
    apply_stimulus(6'b111111, {5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 5'd0}, 1'b0);
    #1;
    check_output("x0_ready", 64'(bus.req_ready), 64'(6'b111101));
    check_output("x0_raddr", 64'(bus.raddr), 64'({5'd7, 5'd7, 5'd7, 5'd7}));
    next_cycle();
    check_output("x0_resp_valid", 64'(bus.resp_valid), 64'(6'b111101));
    check_output("x0_data0", 64'(bus.resp_data[0]), 64'h0);
    check_output("x0_data2", 64'(bus.resp_data[2]), 64'h7777);
    check_output("x0_data5", 64'(bus.resp_data[5]), 64'h7777);

    // Denied req1 keeps its request and is served next (rr_ptr=0)
    apply_stimulus(6'b000010, {5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0}, 1'b0);
    #1;
    check_output("hold_ready", 64'(bus.req_ready), 64'(6'b000010));
    check_output("hold_raddr", 64'(bus.raddr), 64'({5'd0, 5'd0, 5'd0, 5'd7}));
    next_cycle();
    check_output("hold_resp_valid", 64'(bus.resp_valid), 64'(6'b000010));
    check_output("hold_data1", 64'(bus.resp_data[1]), 64'h7777);

    // Forwarding: both write ports hit r5, port 1 wins
    apply_stimulus(6'b000001, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5}, 1'b0);
    set_writes(2'b11, {5'd5, 5'd5}, {32'hBBBB, 32'hAAAA});
    #1;
    check_output("fwd_ready", 64'(bus.req_ready), 64'(6'b000001));
    next_cycle();
    check_output("fwd_resp_valid", 64'(bus.resp_valid), 64'(6'b000001));
    check_output("fwd_data0", 64'(bus.resp_data[0]), 64'hBBBB);

    // Forwarding from write port 0 only (port 1 disabled)
    apply_stimulus(6'b000010, {5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0}, 1'b0);
    set_writes(2'b01, {5'd4, 5'd3}, {32'hDDDD, 32'hCCCC});
    next_cycle();
    check_output("fwd0_data1", 64'(bus.resp_data[1]), 64'hCCCC);

    // Committed value is then read from the ARF itself
    apply_stimulus(6'b000100, {5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0}, 1'b0);
    set_writes(2'b00, '0, '0);
    next_cycle();
    check_output("arf_after_write_data2", 64'(bus.resp_data[2]), 64'hCCCC);

    // Flush: grant req2 in T, flush in T+1 kills it; grant in T+1 under flush
    apply_stimulus(6'b000100, {5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0}, 1'b0);
    next_cycle();
    apply_stimulus(6'b001000, {5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0}, 1'b1);
    #1;
    check_output("flush_t1_resp_valid", 64'(bus.resp_valid), 64'h0);
    check_output("flush_t1_ready", 64'(bus.req_ready), 64'(6'b001000));
    next_cycle();
    apply_stimulus(6'b000100, {5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0}, 1'b0);
    #1;
    check_output("flush_t2_resp_valid", 64'(bus.resp_valid), 64'h0);
    check_output("flush_t2_ready", 64'(bus.req_ready), 64'(6'b000100));
    next_cycle();
    check_output("flush_t3_resp_valid", 64'(bus.resp_valid), 64'(6'b000100));
    check_output("flush_t3_data2", 64'(bus.resp_data[2]), 64'h2222);

    // No requests: no grants, no response
    apply_stimulus(6'b000000, '0, 1'b0);
    #1;
    check_output("idle_ready", 64'(bus.req_ready), 64'h0);
    check_output("idle_raddr", 64'(bus.raddr), 64'h0);
    next_cycle();
    check_output("idle_resp_valid", 64'(bus.resp_valid), 64'h0);

    // Mid-flight async reset: move rr_ptr to 4, grant req4, reset before response
    apply_stimulus(6'b111111, {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 1'b0);
    next_cycle();
    apply_stimulus(6'b010000, {5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0}, 1'b0);
    #1;
    check_output("areset_pre_ready", 64'(bus.req_ready), 64'(6'b010000));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("areset_resp_valid", 64'(bus.resp_valid), 64'h0);
    check_output("areset_ready", 64'(bus.req_ready), 64'h0);
    apply_stimulus(6'b000000, '0, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    #1;
    check_output("areset_release_resp_valid", 64'(bus.resp_valid), 64'h0);
    apply_stimulus(6'b111111, {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 1'b0);
    #1;
    check_output("areset_rr_ptr_ready", 64'(bus.req_ready), 64'(6'b001111));
    next_cycle();
    check_output("areset_post_resp_valid", 64'(bus.resp_valid), 64'(6'b001111));
    check_output("areset_post_data3", 64'(bus.resp_data[3]), 64'h4444);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
